// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a single outstanding fill.
// Hits are answered combinationally in IDLE; misses stall in FETCH until memory grants.
module icache #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hitcnt,
  output logic [31:0] misscnt
);

  localparam int unsigned IDXW = $clog2(SETS);
  localparam int unsigned TAGW = 30 - IDXW;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [SETS-1:0] valid_q;
  logic [TAGW-1:0] tag_q  [SETS];
  logic [31:0]     data_q [SETS];
  logic [29:0]     miss_q;
  logic [31:0]     hitcnt_q, misscnt_q;

  logic [IDXW-1:0] req_idx, fill_idx;
  logic [TAGW-1:0] req_tag, fill_tag;
  logic            lookup_hit;
  logic            miss_ld;
  logic            fill_en;
  logic            unused_byte_offset;

  // Request and latched-miss address decode; miss_q holds the word address.
  assign req_idx            = imemaddr[2 +: IDXW];
  assign req_tag            = imemaddr[31 -: TAGW];
  assign fill_idx           = miss_q[0 +: IDXW];
  assign fill_tag           = miss_q[29 -: TAGW];
  assign unused_byte_offset = ^imemaddr[1:0];

  // Next-state and combinational lookup/memory-side outputs.
  always_comb begin
    state_d    = state_q;
    miss_ld    = 1'b0;
    fill_en    = 1'b0;
    ihit       = 1'b0;
    iREN       = 1'b0;
    iaddr      = 32'h0;
    lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    case (state_q)
      IDLE: begin
        if (imemREN && !flush) begin
          if (lookup_hit) begin
            ihit = 1'b1;
          end else begin
            miss_ld = 1'b1;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {miss_q, 2'b00};
        // Flush aborts the fill outright; otherwise wait for the grant.
        if (flush) begin
          state_d = IDLE;
        end else if (!iwait) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imemload = ihit ? data_q[req_idx] : 32'h0;
  assign hitcnt   = hitcnt_q;
  assign misscnt  = misscnt_q;

  // Control state, valid bits and counters.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      miss_q    <= '0;
      hitcnt_q  <= '0;
      misscnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_ld) begin
        miss_q <= imemaddr[31:2];
      end
      if (flush) begin
        valid_q <= '0;
      end else if (fill_en) begin
        valid_q[fill_idx] <= 1'b1;
      end
      hitcnt_q <= hitcnt_q + 32'(ihit);
      if (fill_en) begin
        misscnt_q <= misscnt_q + 32'd1;
      end
    end
  end

  // Tag/data arrays carry no reset; valid_q alone qualifies their contents.
  always_ff @(posedge CLK) begin
    if (nRST && fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios plus randomized traffic checked every cycle
// against an associative-array cache model and a simple memory model.
module tb_icache;

  localparam int unsigned SETS = 16;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hitcnt;
  logic [31:0] misscnt;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  // Model: cached word address and data per index, pending fill, counters.
  logic [31:0] m_line [int];
  logic [31:0] m_data [int];
  bit          m_fetch;
  logic [31:0] m_miss;
  logic [31:0] m_hits;
  logic [31:0] m_misses;

  icache #(.SETS(SETS)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .flush    (flush),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .hitcnt   (hitcnt),
    .misscnt  (misscnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h3C01_1234;
  endfunction

  // One clock: drive at negedge, check outputs against the model, then advance the model.
  task automatic cycle(input bit rst_n, input bit ren, input logic [31:0] addr,
                       input bit fl, input bit wt);
    logic [31:0] word;
    int          idx;
    bit          exp_hit;
    @(negedge CLK);
    nRST     = rst_n;
    imemREN  = ren;
    imemaddr = addr;
    flush    = fl;
    iwait    = wt;
    iload    = iREN ? mem_word(iaddr) : $urandom();
    #1;
    word    = addr & 32'hFFFF_FFFC;
    idx     = int'((addr >> 2) % SETS);
    exp_hit = !m_fetch && ren && !fl && m_line.exists(idx) && (m_line[idx] == word);
    if (chk_on) begin
      check("ihit", 32'(ihit), 32'(exp_hit));
      check("imemload", imemload, exp_hit ? m_data[idx] : 32'h0);
      check("iREN", 32'(iREN), 32'(m_fetch));
      check("iaddr", iaddr, m_fetch ? m_miss : 32'h0);
      check("hitcnt", hitcnt, m_hits);
      check("misscnt", misscnt, m_misses);
    end
    if (!rst_n) begin
      m_fetch  = 1'b0;
      m_hits   = 32'h0;
      m_misses = 32'h0;
      m_line.delete();
      m_data.delete();
    end else begin
      if (exp_hit) m_hits++;
      if (fl) begin
        m_line.delete();
        m_data.delete();
        m_fetch = 1'b0;
      end else if (m_fetch) begin
        if (!wt) begin
          idx         = int'((m_miss >> 2) % SETS);
          m_line[idx] = m_miss;
          m_data[idx] = mem_word(m_miss);
          m_misses++;
          m_fetch     = 1'b0;
        end
      end else if (ren && !exp_hit) begin
        m_fetch = 1'b1;
        m_miss  = word;
      end
    end
  endtask

  // Request an address until it hits, bounded.
  task automatic fill(input logic [31:0] a);
    bit got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      cycle(1'b1, 1'b1, a, 1'b0, 1'b0);
      if (ihit) got = 1'b1;
    end
    check("fill_done", 32'(got), 32'd1);
  endtask

  initial begin
    int n_ren;
    int first_hit;
    logic [31:0] a;

    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; flush = 1'b0; iwait = 1'b0; iload = '0;
    m_fetch = 1'b0; m_miss = '0; m_hits = '0; m_misses = '0;

    // Reset
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_on = 1'b1;
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("rst_ihit", 32'(ihit), 32'd0);
    check("rst_imemload", imemload, 32'h0);
    check("rst_iREN", 32'(iREN), 32'd0);
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_hitcnt", hitcnt, 32'h0);
    check("rst_misscnt", misscnt, 32'h0);

    // Cold miss with immediate grant
    cycle(1'b1, 1'b1, 32'h4, 1'b0, 1'b0);
    check("cold_c0_iREN", 32'(iREN), 32'd0);
    cycle(1'b1, 1'b1, 32'h4, 1'b0, 1'b0);
    check("cold_c1_iREN", 32'(iREN), 32'd1);
    check("cold_c1_iaddr", iaddr, 32'h4);
    cycle(1'b1, 1'b1, 32'h4, 1'b0, 1'b0);
    check("cold_c2_ihit", 32'(ihit), 32'd1);
    check("cold_c2_load", imemload, mem_word(32'h4));
    check("cold_c2_misscnt", misscnt, 32'd1);
    cycle(1'b1, 1'b1, 32'h4, 1'b0, 1'b0);
    check("cold_c3_hitcnt", hitcnt, 32'd1);

    // Three wait states
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    n_ren = 0;
    first_hit = -1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 32'h4, 1'b0, (i >= 1 && i <= 3));
      if (iREN) n_ren++;
      if (ihit && first_hit < 0) first_hit = i;
    end
    check("wait_iren_cycles", 32'(n_ren), 32'd4);
    check("wait_first_hit", 32'(first_hit), 32'd5);
    check("wait_misscnt", misscnt, 32'd1);

    // Conflict eviction on a shared index
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    fill(32'h0);
    fill(32'h40);
    cycle(1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    check("conflict_ihit", 32'(ihit), 32'd0);
    cycle(1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    check("conflict_iREN", 32'(iREN), 32'd1);
    check("conflict_iaddr", iaddr, 32'h0);
    cycle(1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    check("conflict_misscnt", misscnt, 32'd3);

    // Flush in IDLE, then flush aborting a fill
    fill(32'h4);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h4, 1'b0, 1'b0);
    check("flush_miss", 32'(ihit), 32'd0);
    cycle(1'b1, 1'b1, 32'h4, 1'b1, 1'b0);
    check("flush_fetch_iREN", 32'(iREN), 32'd1);
    check("flush_fetch_ihit", 32'(ihit), 32'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("flush_abort_iREN", 32'(iREN), 32'd0);
    check("flush_abort_misscnt", misscnt, 32'd4);

    // Reset while a fill is stalled
    cycle(1'b1, 1'b1, 32'h8, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'h8, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("rstmid_iREN", 32'(iREN), 32'd0);
    check("rstmid_hitcnt", hitcnt, 32'h0);
    check("rstmid_misscnt", misscnt, 32'h0);
    cycle(1'b1, 1'b1, 32'h8, 1'b0, 1'b1);
    check("rstmid_remiss", 32'(ihit), 32'd0);

    // Address changes while the fill for 0x8 is stalled
    cycle(1'b1, 1'b1, 32'hC, 1'b0, 1'b1);
    check("addrchg_iaddr_w", iaddr, 32'h8);
    cycle(1'b1, 1'b1, 32'hC, 1'b0, 1'b0);
    check("addrchg_iaddr_g", iaddr, 32'h8);
    cycle(1'b1, 1'b1, 32'hC, 1'b0, 1'b0);
    check("addrchg_c_miss", 32'(ihit), 32'd0);
    cycle(1'b1, 1'b1, 32'hC, 1'b0, 1'b0);
    check("addrchg_c_iaddr", iaddr, 32'hC);
    cycle(1'b1, 1'b1, 32'h8, 1'b0, 1'b0);
    check("addrchg_8_hit", 32'(ihit), 32'd1);
    check("addrchg_8_load", imemload, mem_word(32'h8));

    // Randomized traffic over a small address pool to force reuse and conflicts
    for (int i = 0; i < 3000; i++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) a[31:28] = 4'hF;
      cycle($urandom_range(0, 99) != 0,
            $urandom_range(0, 9) < 8,
            a,
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 9) < 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
